// File: rtl/reflet_deserializer_pkg.sv
// Shared constants for the reflet deserializer: state encodings, default word size
// and the REFLET_DESERIALIZER_PARITY_EN feature guard.
package reflet_deserializer_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam int unsigned DEFAULT_WORD_SIZE = 8;

`ifdef REFLET_DESERIALIZER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Strobes needed per frame: data bits plus the optional trailing parity bit.
  function automatic int unsigned frame_bits(input int unsigned word_size);
    return word_size + (PARITY_EN ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/reflet_deser_shift.sv
// Bit counter and assembly register: turns enable/sync/in strobes into a word
// plus a single-cycle word_done, combinationally aligned with the completing strobe.
module reflet_deser_shift
  import reflet_deserializer_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sync,
  input  logic                 in,
  output logic [WORD_SIZE-1:0] word,
  output logic                 word_done,
  output logic                 parity_ok,
  output logic                 busy
);

  localparam int unsigned NBITS = frame_bits(WORD_SIZE);
  localparam int unsigned CW    = $clog2(NBITS + 1);

  logic [0:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        pos;
  logic [WORD_SIZE-1:0] shreg_q, shreg_d;
  logic [WORD_SIZE-1:0] bit_vec;
  logic                 par_q, par_d;

  assign bit_vec = {{(WORD_SIZE-1){1'b0}}, in};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    word_done = 1'b0;
    pos       = '0;
    if (enable) begin
      if (sync) begin
        // sync restarts the word from any state, discarding a partial one
        pos     = LSB_FIRST ? '0 : CW'(WORD_SIZE - 1);
        shreg_d = bit_vec << pos;
        par_d   = in;
        cnt_d   = CW'(1);
        state_d = ST_SHIFT;
      end else if (state_q == ST_SHIFT) begin
        pos   = LSB_FIRST ? cnt_q : CW'(WORD_SIZE - 1) - cnt_q;
        par_d = par_q ^ in;
        if (cnt_q < CW'(WORD_SIZE)) begin
          shreg_d = shreg_q | (bit_vec << pos);
        end
        if (cnt_q == CW'(NBITS - 1)) begin
          word_done = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  assign word      = shreg_d;
  assign parity_ok = PARITY_EN ? ~par_d : 1'b1;
  assign busy      = (state_q == ST_SHIFT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
    end
  end

endmodule

// File: rtl/reflet_deserializer.sv
// Serial-to-parallel receiver with a one-word valid/ready holding register and sticky
// overrun flag; REFLET_DESERIALIZER_PARITY_EN adds an even-parity bit and parity_error.
module reflet_deserializer
  import reflet_deserializer_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in,
  input  logic                 sync,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 clear_flags
`ifdef REFLET_DESERIALIZER_PARITY_EN
  ,
  output logic                 parity_error
`endif
);

  logic [WORD_SIZE-1:0] word;
  logic                 word_done;
  logic                 parity_ok;
  logic                 word_ok;
  logic                 accept;

  logic [WORD_SIZE-1:0] hold_q, hold_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  reflet_deser_shift #(
    .WORD_SIZE(WORD_SIZE),
    .LSB_FIRST(LSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .sync     (sync),
    .in       (in),
    .word     (word),
    .word_done(word_done),
    .parity_ok(parity_ok),
    .busy     (busy)
  );

  assign word_ok = word_done & parity_ok;
  // a word completing while the current one is consumed loads with no bubble
  assign accept  = word_ok & (~valid_q | out_ready);

  always_comb begin
    hold_d    = hold_q;
    valid_d   = valid_q;
    if (accept) begin
      hold_d  = word;
      valid_d = 1'b1;
    end else if (valid_q & out_ready) begin
      valid_d = 1'b0;
    end
    overrun_d = (word_ok & ~accept) | (overrun_q & ~clear_flags);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_data  = hold_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

`ifdef REFLET_DESERIALIZER_PARITY_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = (word_done & ~parity_ok) | (perr_q & ~clear_flags);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_error = perr_q;
`endif

endmodule

// File: tb/tb_reflet_deserializer.sv
// Directed bench for reflet_deserializer (LSB-first and MSB-first instances, WORD_SIZE=8).
module tb_reflet_deserializer;

`ifdef REFLET_DESERIALIZER_PARITY_EN
  localparam int unsigned NB = 9;
`else
  localparam int unsigned NB = 8;
`endif

  logic       clk = 1'b0;
  logic       reset, enable, in, sync, out_ready, clear_flags;
  logic [7:0] out_data, m_data;
  logic       out_valid, busy, overrun;
  logic       m_valid, m_busy, m_overrun;
`ifdef REFLET_DESERIALIZER_PARITY_EN
  logic       parity_error, m_perr;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  reflet_deserializer #(.WORD_SIZE(8), .LSB_FIRST(1'b1)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .in(in), .sync(sync),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun(overrun), .clear_flags(clear_flags)
`ifdef REFLET_DESERIALIZER_PARITY_EN
    , .parity_error(parity_error)
`endif
  );

  reflet_deserializer #(.WORD_SIZE(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset), .enable(enable), .in(in), .sync(sync),
    .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
    .busy(m_busy), .overrun(m_overrun), .clear_flags(clear_flags)
`ifdef REFLET_DESERIALIZER_PARITY_EN
    , .parity_error(m_perr)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic fbit(input logic [7:0] w, input int unsigned i);
    if (i < 8) return w[i];
    return ^w;
  endfunction

  // one strobe, then `gap` idle cycles with junk on in/sync
  task automatic send_bit(input logic b, input logic s, input int unsigned gap);
    enable = 1'b1; in = b; sync = s;
    tick();
    enable = 1'b0; in = 1'b0; sync = 1'b0;
    for (int unsigned g = 0; g < gap; g++) begin
      in   = 1'($urandom_range(0, 1));
      sync = 1'($urandom_range(0, 1));
      tick();
    end
    in = 1'b0; sync = 1'b0;
  endtask

  task automatic send_part(input logic [7:0] w, input int unsigned n, input int unsigned gap);
    for (int unsigned i = 0; i < n; i++) send_bit(fbit(w, i), i == 0, gap);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; in = 1'b0; sync = 1'b0;
    out_ready = 1'b1; clear_flags = 1'b0;
    tick(); tick();
    chk("reset_valid",   32'(out_valid), 32'h0);
    chk("reset_busy",    32'(busy),      32'h0);
    chk("reset_data",    32'(out_data),  32'h0);
    chk("reset_overrun", 32'(overrun),   32'h0);
    reset = 1'b1;
    tick();

    // reset in the middle of a word
    send_part(8'hFF, 3, 0);
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_busy",  32'(busy),      32'h0);
    chk("midrst_data",  32'(out_data),  32'h0);

    // plain 0xA5, latency and single word
    send_part(8'hA5, NB - 1, 0);
    chk("a5_pre_valid", 32'(out_valid), 32'h0);
    chk("a5_pre_busy",  32'(busy),      32'h1);
    send_bit(fbit(8'hA5, NB - 1), 1'b0, 0);
    chk("a5_valid",     32'(out_valid), 32'h1);
    chk("a5_data",      32'(out_data),  32'hA5);
    chk("a5_msb_data",  32'(m_data),    32'hA5);
    chk("a5_busy_done", 32'(busy),      32'h0);
    tick();
    chk("a5_consumed", 32'(out_valid), 32'h0);
    tick();
    chk("a5_one_word", 32'(out_valid), 32'h0);

    // strobe gaps with junk between strobes
    out_ready = 1'b0;
    send_bit(fbit(8'hA5, 0), 1'b1, 2);
    chk("gap_busy_first", 32'(busy), 32'h1);
    for (int unsigned i = 1; i < NB - 1; i++) send_bit(fbit(8'hA5, i), 1'b0, 2);
    chk("gap_busy_mid",  32'(busy),      32'h1);
    chk("gap_pre_valid", 32'(out_valid), 32'h0);
    send_bit(fbit(8'hA5, NB - 1), 1'b0, 2);
    chk("gap_data",  32'(out_data),  32'hA5);
    chk("gap_valid", 32'(out_valid), 32'h1);
    chk("gap_busy",  32'(busy),      32'h0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("gap_consumed", 32'(out_valid), 32'h0);

    // resync after a 5-bit partial word
    out_ready = 1'b1;
    send_part(8'h1F, 5, 0);
    chk("resync_partial_valid", 32'(out_valid), 32'h0);
    send_part(8'h3C, NB - 1, 0);
    chk("resync_pre_valid", 32'(out_valid), 32'h0);
    send_bit(fbit(8'h3C, NB - 1), 1'b0, 0);
    chk("resync_data",  32'(out_data),  32'h3C);
    chk("resync_valid", 32'(out_valid), 32'h1);
    tick();
    chk("resync_consumed", 32'(out_valid), 32'h0);

    // backpressure and overrun
    out_ready = 1'b0;
    send_part(8'h11, NB, 0);
    chk("bp_valid1",   32'(out_valid), 32'h1);
    chk("bp_data1",    32'(out_data),  32'h11);
    chk("bp_msb_data", 32'(m_data),    32'h88);
    send_part(8'h22, NB, 0);
    chk("bp_data_kept", 32'(out_data),  32'h11);
    chk("bp_overrun",   32'(overrun),   32'h1);
    chk("bp_valid2",    32'(out_valid), 32'h1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("bp_drain_valid",  32'(out_valid), 32'h0);
    chk("bp_overrun_kept", 32'(overrun),   32'h1);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    chk("bp_overrun_clr", 32'(overrun), 32'h0);

    // back-to-back: completion coincides with consumption
    send_part(8'h5A, NB, 0);
    chk("b2b_data1", 32'(out_data), 32'h5A);
    send_part(8'hC3, NB - 1, 0);
    out_ready = 1'b1;
    send_bit(fbit(8'hC3, NB - 1), 1'b0, 0);
    out_ready = 1'b0;
    chk("b2b_valid",   32'(out_valid), 32'h1);
    chk("b2b_data2",   32'(out_data),  32'hC3);
    chk("b2b_overrun", 32'(overrun),   32'h0);

    // new overrun together with clear_flags: set wins
    send_part(8'h99, NB - 1, 0);
    clear_flags = 1'b1;
    send_bit(fbit(8'h99, NB - 1), 1'b0, 0);
    clear_flags = 1'b0;
    chk("setwins_overrun", 32'(overrun),  32'h1);
    chk("setwins_data",    32'(out_data), 32'hC3);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    chk("setwins_clr", 32'(overrun), 32'h0);
    out_ready = 1'b1; tick();
    chk("final_drain", 32'(out_valid), 32'h0);

`ifdef REFLET_DESERIALIZER_PARITY_EN
    send_part(8'h07, 8, 0);
    send_bit(1'b1, 1'b0, 0);
    chk("par_good_valid", 32'(out_valid),    32'h1);
    chk("par_good_data",  32'(out_data),     32'h07);
    chk("par_good_err",   32'(parity_error), 32'h0);
    tick();
    send_part(8'h07, 8, 0);
    send_bit(1'b0, 1'b0, 0);
    chk("par_bad_valid", 32'(out_valid),    32'h0);
    chk("par_bad_err",   32'(parity_error), 32'h1);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    chk("par_err_clr", 32'(parity_error), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reflet_deserializer.md
Name: reflet_deserializer

Overview:
- Receiving end of a serial bit stream: collects bits sampled on `enable` strobes into parallel words.
- Sync-aligned and presented on a valid/ready output with a one-word holding register.
- Counterpart to the team's shift-based delay/serialising blocks; used where a single-wire stream (inter-block link, pixel/config stream) must become words again.

Parameters:
- WORD_SIZE, 8, data bits per word; legal range 2..32.
- LSB_FIRST, 1, 1: first received bit lands in out_data[0]; 0: first bit lands in out_data[WORD_SIZE-1].

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  bit strobe; `in` and `sync` are sampled only when high.
- in  input  1  serial data bit.
- sync  input  1  marks the current bit as bit 0 of a new word; meaningful only when enable=1.
- out_data  output  WORD_SIZE  assembled word; stable while out_valid=1.
- out_valid  output  1  holding register contains an unconsumed word.
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready.
- busy  output  1  high while in SHIFT state.
- overrun  output  1  sticky: a completed word was dropped because the holding register was full.
- clear_flags  input  1  one-cycle pulse; clears sticky flags.

Behaviour:
- Reset (reset=0 at a clock edge) has priority over everything:
  - out_data=0, out_valid=0, overrun=0, busy=0.
  - Bit counter cleared, state=IDLE.
  - Reset mid-word discards the partial word.
- State IDLE:
  - Bits are ignored until enable & sync.
  - That bit is stored as bit 0, counter=1, state goes to SHIFT.
- State SHIFT:
  - Each enable stores `in` at position `counter` (mirrored when LSB_FIRST=0) and increments the counter.
  - enable=0 cycles hold all state.
- Resync: enable & sync while in SHIFT discards the partial word. The current bit becomes bit 0 and counter=1; no word is emitted.
- Word completion: on the enable that stores bit WORD_SIZE-1:
  - Word moves to the holding register; state returns to IDLE.
  - Latency: out_valid rises the cycle after that edge, i.e. one clock after the last bit's strobe edge.
- Holding register:
  - out_valid clears on out_valid & out_ready.
  - A completing word is accepted if out_valid=0, or if out_valid & out_ready in the same cycle. In that case the new word is loaded and out_valid stays 1 (back-to-back, no bubble).
  - Otherwise the new word is dropped, out_data is unchanged, and overrun is set.
- overrun stays set until clear_flags or reset.
  - If clear_flags and a new overrun coincide, overrun remains 1 (set wins).
- Counter width is $clog2(WORD_SIZE+1); the counter never exceeds WORD_SIZE.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro REFLET_DESERIALIZER_PARITY_EN.
- Defined:
  - Each word is followed by one extra even-parity bit (counter runs to WORD_SIZE+1).
  - The word is offered only if parity over data+parity bit is even.
  - On mismatch the word is discarded and sticky output parity_error (1 bit, reset 0) is set; it is cleared by clear_flags.
  - The parity bit counts as the completing bit for latency purposes.
- Undefined: no parity bit and no parity_error port; behaviour is exactly as above.

Decomposition:
- Shared package/header holds:
  - State encoding constants (IDLE=0, SHIFT=1).
  - Default WORD_SIZE.
  - The parity-feature macro guard.
- One natural sub-module: reflet_deser_shift, containing the bit counter plus shift/assembly register (enable, sync, in -> word, word_done).
- Top level holds the holding register, handshake and flags.

Test Plan:
- Reset mid-word: sync+3 bits, then reset low for 1 cycle -> out_valid=0, busy=0, out_data=0; the next full word is received correctly.
- LSB_FIRST=1, WORD_SIZE=8: sync on the first bit, stream 1,0,1,0,0,1,0,1 with out_ready=1 -> out_data=0xA5, out_valid high 1 cycle after the 8th strobe, exactly one word.
- Strobe gaps: same word with enable=1 every 3rd cycle and junk on `in` when enable=0 -> out_data=0xA5; busy high from first to last strobe.
- Resync: sync+5 bits of 1, then sync + 0x3C bitstream -> only 0x3C is delivered; no word for the partial.
- Backpressure: out_ready=0, deliver 0x11 then 0x22 -> out_data stays 0x11 and overrun=1. Then out_ready=1 for 1 cycle -> out_valid=0. clear_flags -> overrun=0.
- PARITY_EN: 0x07 followed by parity 1 -> delivered; 0x07 followed by parity 0 -> not delivered, parity_error=1.
